tb_console_mmio: RTL and testbench

Memory-mapped simulation console and end-of-test controller for the RS5 test environment. It sits in the 0x8xxx_xxxx peripheral region, decodes CPU stores to the END, per-channel CHAR and INT registers, and buffers output records in a FIFO. Records leave through a valid/ready stream that the simulation wrapper prints. The block also provides a cycle watchdog, readable status, and a drained end-of-simulation handshake.

---
 rtl/tb_console_mmio.sv | 227 ++++++++++++++++++++++
 tb/tb_tb_console_mmio.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tb_console_mmio.sv
// rtl/tb_console_mmio.sv - memory-mapped simulation console and end-of-test controller
//
// Purpose: decodes CPU stores to END / CHAR[ch] / INT registers, buffers the
// resulting output records in a FIFO drained through a valid/ready stream,
// runs a cycle watchdog, exposes STATUS/CYCLES/DROPS for reads and performs
// a drained end-of-simulation handshake.
//
// Ports:
//   clk, reset             clock (rising edge), synchronous active-high reset
//   en_i                   region select (already decoded from the address MSBs)
//   we_i[3:0]              byte write enables; nonzero = write, zero = read
//   addr_i[15:0]           offset within the region
//   data_i[31:0]           write data
//   data_o[31:0]           registered read data (0 when no read the cycle before)
//   out_valid_o/out_ready_i record stream handshake
//   out_type_o             0 = CHAR, 1 = INT
//   out_ch_o[2:0]          CHAR channel, 0 for INT
//   out_data_o[31:0]       record payload
//   done_o                 end of simulation reached (sticky)
//   exit_code_o[7:0]       latched exit code
//   timeout_o              watchdog fired (sticky)

module tb_console_mmio #(
   parameter int FIFO_DEPTH     = 16,
   parameter int NUM_CH         = 4,
   parameter int TIMEOUT_CYCLES = 50000,
   parameter int CNT_W          = 32
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        en_i,
   input  logic [3:0]  we_i,
   input  logic [15:0] addr_i,
   input  logic [31:0] data_i,
   output logic [31:0] data_o,
   output logic        out_valid_o,
   input  logic        out_ready_i,
   output logic        out_type_o,
   output logic [2:0]  out_ch_o,
   output logic [31:0] out_data_o,
   output logic        done_o,
   output logic [7:0]  exit_code_o,
   output logic        timeout_o
);

   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int CNT_FW = $clog2(FIFO_DEPTH + 1);
   localparam int REC_W  = 36;   // {type, ch[2:0], data[31:0]}

   localparam logic [1:0] ST_RUN   = 2'd0;
   localparam logic [1:0] ST_DRAIN = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   localparam logic              WD_EN    = (TIMEOUT_CYCLES != 0);
   localparam logic [CNT_W-1:0]  WD_LIMIT = CNT_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);
   localparam logic [CNT_FW-1:0] DEPTH_C  = CNT_FW'(FIFO_DEPTH);
   localparam logic [CNT_FW-1:0] CNT_ONE  = CNT_FW'(1);
   localparam logic [PTR_W-1:0]  PTR_ONE  = PTR_W'(1);
   localparam logic [CNT_W-1:0]  CYC_ONE  = CNT_W'(1);

   // ---------------- state ----------------
   logic [1:0]        state_q, state_d;
   logic [CNT_FW-1:0] count_q, count_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic              ovf_q, ovf_d;
   logic              timeout_q, timeout_d;
   logic [7:0]        exit_q, exit_d;
   logic [CNT_W-1:0]  cycles_q, cycles_d;
   logic [CNT_W-1:0]  drops_q, drops_d;
   logic [31:0]       data_q, data_d;
   logic [REC_W-1:0]  mem_q [FIFO_DEPTH];

   // ---------------- address decode ----------------
   logic       acc_wr, acc_rd;
   logic       hit_end, hit_char, hit_int;
   logic [9:0] char_idx;
   logic       char_nul;
   logic       wr_rec;      // write that would produce a record
   logic       rec_req;     // any console write (record or END)

   assign acc_wr   = en_i && (we_i != 4'b0000);
   assign acc_rd   = en_i && (we_i == 4'b0000);
   assign char_idx = addr_i[11:2];
   assign char_nul = (data_i[7:0] == 8'h00);
   assign hit_end  = acc_wr && (addr_i == 16'h0000);
   assign hit_int  = acc_wr && (addr_i == 16'h2000);
   assign hit_char = acc_wr && (addr_i[15:12] == 4'h1) && (addr_i[1:0] == 2'b00)
                     && (32'(char_idx) < 32'(NUM_CH));
   // NUL characters never become records and are never counted as drops
   assign wr_rec   = (hit_char && !char_nul) || hit_int;
   assign rec_req  = wr_rec || hit_end;

   // ---------------- FIFO control ----------------
   logic             push_req, push_ok, pop, drop;
   logic [REC_W-1:0] rec_d;
   logic [REC_W-1:0] head;

   assign head        = mem_q[rd_ptr_q];
   assign out_valid_o = (count_q != '0) && (state_q != ST_DONE);
   assign out_type_o  = out_valid_o ? head[35]    : 1'b0;
   assign out_ch_o    = out_valid_o ? head[34:32] : 3'b000;
   assign out_data_o  = out_valid_o ? head[31:0]  : 32'h0;

   assign pop      = out_valid_o && out_ready_i;
   assign push_req = (state_q == ST_RUN) && wr_rec;
   // a full FIFO still accepts a push when the head leaves in the same cycle
   assign push_ok  = push_req && ((count_q < DEPTH_C) || pop);
   // in DRAIN every console write (except a NUL char) is refused and counted
   assign drop     = (push_req && !push_ok) || ((state_q == ST_DRAIN) && rec_req);
   assign rec_d    = hit_int ? {1'b1, 3'b000, data_i}
                             : {1'b0, addr_i[4:2], 24'h0, data_i[7:0]};

   // ---------------- watchdog ----------------
   logic wd_fire;
   assign wd_fire = WD_EN && (state_q == ST_RUN) && (cycles_q == WD_LIMIT);

   // ---------------- next state ----------------
   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      ovf_d     = ovf_q;
      timeout_d = timeout_q;
      exit_d    = exit_q;
      cycles_d  = cycles_q;
      drops_d   = drops_q;
      data_d    = 32'h0;

      if (cycles_q != '1) begin
         cycles_d = cycles_q + CYC_ONE;
      end

      if (push_ok) begin
         wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      case ({push_ok, pop})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase

      if (drop) begin
         if (push_req) begin
            ovf_d = 1'b1;
         end
         if (drops_q != '1) begin
            drops_d = drops_q + CYC_ONE;
         end
      end

      case (state_q)
         ST_RUN: begin
            // END takes priority over a simultaneous watchdog expiry
            if (hit_end) begin
               state_d = ST_DRAIN;
               exit_d  = data_i[7:0];
            end else if (wd_fire) begin
               state_d   = ST_DRAIN;
               timeout_d = 1'b1;
               exit_d    = 8'hFF;
            end
         end
         ST_DRAIN: begin
            // uses the registered count, so DONE lands one cycle after empty
            if (count_q == '0) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: state_d = ST_DONE;
         default: state_d = ST_RUN;
      endcase

      if (acc_rd) begin
         case (addr_i)
            16'h3000: data_d = {19'h0, state_q, (state_q == ST_DONE), timeout_q, ovf_q, 8'(count_q)};
            16'h3004: data_d = 32'(cycles_q);
            16'h3008: data_d = 32'(drops_q);
            default:  data_d = 32'h0;
         endcase
      end
   end

   // ---------------- registers ----------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_RUN;
         count_q   <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         ovf_q     <= 1'b0;
         timeout_q <= 1'b0;
         exit_q    <= 8'h00;
         cycles_q  <= '0;
         drops_q   <= '0;
         data_q    <= 32'h0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         ovf_q     <= ovf_d;
         timeout_q <= timeout_d;
         exit_q    <= exit_d;
         cycles_q  <= cycles_d;
         drops_q   <= drops_d;
         data_q    <= data_d;
      end
   end

   // record storage needs no reset: entries are only visible while counted
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem_q[wr_ptr_q] <= rec_d;
      end
   end

   assign data_o      = data_q;
   assign done_o      = (state_q == ST_DONE);
   assign exit_code_o = exit_q;
   assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_tb_console_mmio.sv
// tb/tb_tb_console_mmio.sv - scoreboard testbench for tb_console_mmio

module tb_tb_console_mmio;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset = 1'b1;
   logic        en = 1'b0;
   logic [3:0]  we = 4'h0;
   logic [15:0] addr = 16'h0;
   logic [31:0] wdata = 32'h0;
   logic [31:0] rdata;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic        out_type;
   logic [2:0]  out_ch;
   logic [31:0] out_data;
   logic        done;
   logic [7:0]  exit_code;
   logic        timeout;

   logic        w_en = 1'b0;
   logic [3:0]  w_we = 4'h0;
   logic [15:0] w_addr = 16'h0;
   logic [31:0] w_wdata = 32'h0;
   logic [31:0] w_rdata;
   logic        w_valid;
   logic        w_ready = 1'b1;
   logic        w_type;
   logic [2:0]  w_ch;
   logic [31:0] w_data;
   logic        w_done;
   logic [7:0]  w_exit;
   logic        w_timeout;

   tb_console_mmio #(.FIFO_DEPTH(16), .NUM_CH(4), .TIMEOUT_CYCLES(50000), .CNT_W(32)) dut (
      .clk(clk), .reset(reset), .en_i(en), .we_i(we), .addr_i(addr), .data_i(wdata),
      .data_o(rdata), .out_valid_o(out_valid), .out_ready_i(out_ready),
      .out_type_o(out_type), .out_ch_o(out_ch), .out_data_o(out_data),
      .done_o(done), .exit_code_o(exit_code), .timeout_o(timeout)
   );

   tb_console_mmio #(.FIFO_DEPTH(16), .NUM_CH(4), .TIMEOUT_CYCLES(100), .CNT_W(32)) dut_wd (
      .clk(clk), .reset(reset), .en_i(w_en), .we_i(w_we), .addr_i(w_addr), .data_i(w_wdata),
      .data_o(w_rdata), .out_valid_o(w_valid), .out_ready_i(w_ready),
      .out_type_o(w_type), .out_ch_o(w_ch), .out_data_o(w_data),
      .done_o(w_done), .exit_code_o(w_exit), .timeout_o(w_timeout)
   );

   int checks = 0;
   int failures = 0;

   typedef struct packed {
      logic        t;
      logic [2:0]  ch;
      logic [31:0] d;
   } rec_t;
   rec_t sb[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
      end
   endtask

   task automatic push_exp(input logic t, input logic [2:0] ch, input logic [31:0] d);
      rec_t r;
      r.t = t; r.ch = ch; r.d = d;
      sb.push_back(r);
   endtask

   // stream monitor: every accepted record is matched against the scoreboard
   always @(negedge clk) begin
      if (!reset && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL stream_unexpected actual=0x%0h expected=none", {out_type, out_ch, out_data});
         end else begin
            rec_t e;
            e = sb.pop_front();
            chk("stream_rec", {28'h0, out_type, out_ch, out_data}, {28'h0, e});
         end
      end
   end

   // all tasks start and end at 1ns after a rising edge
   task automatic do_reset();
      reset = 1'b1; en = 1'b0; we = 4'h0; out_ready = 1'b0;
      sb.delete();
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
   endtask

   task automatic wr(input logic [15:0] a, input logic [31:0] d);
      en = 1'b1; we = 4'hF; addr = a; wdata = d;
      @(posedge clk); #1;
      en = 1'b0; we = 4'h0;
   endtask

   task automatic rd(input string name, input logic [15:0] a, input logic [31:0] exp);
      en = 1'b1; we = 4'h0; addr = a;
      @(posedge clk); #1;
      en = 1'b0;
      @(negedge clk);
      chk(name, rdata, exp);
      @(posedge clk); #1;
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while (sb.size() != 0 && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      chk(name, sb.size(), 0);
   endtask

   initial begin
      #400000;
      $display("FAIL global_timeout actual=running expected=finished");
      $fatal(1);
   end

   initial begin
      int t_to, t_done, n;

      // ---- reset values and watchdog (TIMEOUT_CYCLES=100 instance) ----
      do_reset();
      @(negedge clk);
      chk("rst_data_o", rdata, 0);
      chk("rst_valid", out_valid, 0);
      chk("rst_stream", {out_type, out_ch, out_data}, 0);
      chk("rst_done", done, 0);
      chk("rst_exit", exit_code, 0);
      chk("rst_timeout", timeout, 0);
      t_to = -1; t_done = -1;
      for (int k = 1; k <= 200; k++) begin
         @(posedge clk); @(negedge clk);
         if (w_timeout && t_to < 0) begin
            t_to = k;
            chk("wd_exit", w_exit, 8'hFF);
            chk("wd_done_not_yet", w_done, 0);
         end
         if (w_done && t_done < 0) t_done = k;
         if (t_done >= 0) break;
      end
      chk("wd_timeout_cycle", t_to, 100);
      chk("wd_done_cycle", t_done, 101);
      @(posedge clk); #1;

      // ---- single CHAR record, 1-cycle latency ----
      do_reset();
      out_ready = 1'b1;
      push_exp(1'b0, 3'd2, 32'h41);
      wr(16'h1008, 32'h0000_0041);
      @(negedge clk);
      chk("t1_valid_after_write", out_valid, 1);
      @(negedge clk);
      chk("t1_valid_one_cycle", out_valid, 0);
      chk("t1_sb_empty", sb.size(), 0);
      @(posedge clk); #1;

      // ---- overflow with ready low ----
      do_reset();
      for (int i = 0; i < 20; i++) begin
         if (i < 16) push_exp(1'b1, 3'd0, 32'(i));
         wr(16'h2000, 32'(i));
      end
      rd("t2_status", 16'h3000, 32'h0000_0110);
      rd("t2_drops", 16'h3008, 32'd4);
      @(negedge clk);
      chk("t2_rd_idle_zero", rdata, 0);
      @(posedge clk); #1;

      // ---- full FIFO: push and pop in the same cycle ----
      out_ready = 1'b1;
      push_exp(1'b1, 3'd0, 32'd100);
      wr(16'h2000, 32'd100);
      out_ready = 1'b0;
      rd("t3_status", 16'h3000, 32'h0000_0110);
      rd("t3_drops", 16'h3008, 32'd4);
      out_ready = 1'b1;
      drain("t3_drain");
      out_ready = 1'b0;

      // ---- END with queued records, DRAIN drops ----
      do_reset();
      push_exp(1'b0, 3'd0, 32'h61);
      wr(16'h1000, 32'hFFFF_FF61);
      push_exp(1'b0, 3'd3, 32'h62);
      wr(16'h100C, 32'h0000_0062);
      push_exp(1'b1, 3'd0, 32'hDEAD_BEEF);
      wr(16'h2000, 32'hDEAD_BEEF);
      wr(16'h0000, 32'h0000_0005);
      rd("t4_status_drain", 16'h3000, 32'h0000_0803);
      wr(16'h1004, 32'h0000_0043);
      rd("t4_drops", 16'h3008, 32'd1);
      chk("t4_not_done", done, 0);
      repeat (5) begin @(posedge clk); #1; end
      out_ready = 1'b1;
      n = 0;
      while (!done && n < 50) begin @(posedge clk); #1; n++; end
      chk("t4_done", done, 1);
      chk("t4_sb_empty", sb.size(), 0);
      chk("t4_exit", exit_code, 8'h05);
      chk("t4_timeout", timeout, 0);
      chk("t4_valid_done", out_valid, 0);
      rd("t4_status_done", 16'h3000, 32'h0000_1400);
      out_ready = 1'b0;

      // ---- END with empty FIFO: done one cycle after DRAIN ----
      do_reset();
      wr(16'h0000, 32'h1234_5607);
      @(negedge clk);
      chk("t5_done_n", done, 0);
      @(negedge clk);
      chk("t5_done_n1", done, 1);
      chk("t5_exit", exit_code, 8'h07);
      @(posedge clk); #1;

      // ---- NUL char, out-of-range channel, unmapped read ----
      do_reset();
      out_ready = 1'b1;
      wr(16'h1000, 32'h0000_0000);
      wr(16'h1010, 32'h0000_0055);
      wr(16'h7000, 32'h0000_0099);
      rd("t6_unmapped_read", 16'h7000, 32'h0);
      rd("t6_drops", 16'h3008, 32'd0);
      rd("t6_status", 16'h3000, 32'h0);
      chk("t6_no_records", sb.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
